// File: rtl/cpu_dec_pkg.sv
// cpu_dec_pkg: shared types and constants for the CPU decoder-region read responder.
// Holds size encodings, tag lane codes, the FSM state enum, the request
// queue entry struct, the timeout fill word and the entry builder used at push.
package cpu_dec_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] TAG_B0 = 4'b0000;
  localparam logic [3:0] TAG_B1 = 4'b0001;
  localparam logic [3:0] TAG_B2 = 4'b0010;
  localparam logic [3:0] TAG_B3 = 4'b0011;
  localparam logic [3:0] TAG_H0 = 4'b0100;
  localparam logic [3:0] TAG_H2 = 4'b0110;
  localparam logic [3:0] TAG_W  = 4'b1000;
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [8:0]  tag;
    logic        bad;
  } entry_t;

  // Builds a queue entry: word-aligned address, lane strobes, replicated
  // store data, {lane code, dest reg} tag and the misaligned/illegal flag.
  function automatic entry_t make_entry(input logic write, input logic [31:0] addr,
                                        input logic [1:0] size, input logic [31:0] wdata,
                                        input logic [4:0] dest);
    entry_t e;
    e.write = write;
    e.addr  = {addr[31:2], 2'b00};
    e.wstrb = size == SIZE_BYTE ? 4'b0001 << addr[1:0] :
              size == SIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
              size == SIZE_WORD ? 4'b1111 : 4'b0000;
    e.wdata = size == SIZE_BYTE ? {4{wdata[7:0]}} :
              size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    e.tag   = {size == SIZE_BYTE ? (TAG_B0 | {2'b00, addr[1:0]}) :
               size == SIZE_HALF ? (addr[1] ? TAG_H2 : TAG_H0) : TAG_W, dest};
    e.bad   = size == SIZE_HALF ? addr[0] :
              size == SIZE_WORD ? |addr[1:0] : size != SIZE_BYTE;
    return e;
  endfunction
endpackage

// File: rtl/cpu_dec_read_responder_if.sv
// cpu_dec_read_responder_if: CPU request/read-return and peripheral bus signals.
// slave  - responder view: takes CPU requests, drives the peripheral bus.
// master - environment view: drives CPU requests and peripheral responses.
interface cpu_dec_read_responder_if;
  logic        cpu_dec_request;
  logic        cpu_dec_ready;
  logic        cpu_dec_write;
  logic [31:0] cpu_dec_addr;
  logic [1:0]  cpu_dec_size;
  logic [31:0] cpu_dec_wdata;
  logic [4:0]  cpu_dec_dest_reg;
  logic        cpu_dec_rvalid;
  logic [31:0] cpu_dec_rdata;
  logic [8:0]  cpu_dec_rtag;
  logic        per_valid;
  logic        per_ready;
  logic        per_write;
  logic [31:0] per_addr;
  logic [3:0]  per_wstrb;
  logic [31:0] per_wdata;
  logic        per_rvalid;
  logic [31:0] per_rdata;

  modport slave (
    input  cpu_dec_request, cpu_dec_write, cpu_dec_addr, cpu_dec_size, cpu_dec_wdata, cpu_dec_dest_reg,
    output cpu_dec_ready, cpu_dec_rvalid, cpu_dec_rdata, cpu_dec_rtag,
    output per_valid, per_write, per_addr, per_wstrb, per_wdata,
    input  per_ready, per_rvalid, per_rdata
  );

  modport master (
    output cpu_dec_request, cpu_dec_write, cpu_dec_addr, cpu_dec_size, cpu_dec_wdata, cpu_dec_dest_reg,
    input  cpu_dec_ready, cpu_dec_rvalid, cpu_dec_rdata, cpu_dec_rtag,
    input  per_valid, per_write, per_addr, per_wstrb, per_wdata,
    output per_ready, per_rvalid, per_rdata
  );
endinterface

// File: rtl/cpu_dec_req_queue.sv
// cpu_dec_req_queue: DEPTH-entry circular FIFO of request entries.
// Ports: clock, reset_n (async active-low); push_i/data_i write side;
// pop_i/data_o read side (data_o shows the head); full_o, empty_o status.
// Pointers carry one extra wrap bit to tell full from empty.
module cpu_dec_req_queue import cpu_dec_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/cpu_dec_read_responder.sv
// cpu_dec_read_responder: queues CPU decoder-region loads/stores, issues them one
// at a time on the peripheral bus and returns each load as a one-cycle tagged pulse.
// Ports: clock, reset_n (async active-low); bus (slave modport: CPU request and
// read-return signals, peripheral request/response signals); error_misaligned
// (sticky). Build option CPU_DEC_TIMEOUT_EN adds parameter TIMEOUT_CYCLES and the
// sticky timeout_err output; a load with no per_rvalid then returns 32'hDEADBEEF.
module cpu_dec_read_responder import cpu_dec_pkg::*; #(
  parameter int REQ_DEPTH = 2
`ifdef CPU_DEC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic clock,
  input  logic reset_n,
  cpu_dec_read_responder_if.slave bus,
  output logic error_misaligned
`ifdef CPU_DEC_TIMEOUT_EN
  , output logic timeout_err
`endif
);
  state_t state_q, state_d;
  entry_t push_entry, head;
  logic push, pop, full, empty;
  logic per_valid_q, per_valid_d, per_write_q, per_write_d, err_q, err_d;
  logic [31:0] per_addr_q, per_addr_d, per_wdata_q, per_wdata_d, rdata_q, rdata_d;
  logic [3:0] per_wstrb_q, per_wstrb_d;
  logic [8:0] rtag_q, rtag_d;
`ifdef CPU_DEC_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic tmo_err_q, tmo_err_d;
  assign timeout_err = tmo_err_q;
`endif

  assign push_entry = make_entry(bus.cpu_dec_write, bus.cpu_dec_addr, bus.cpu_dec_size,
                                 bus.cpu_dec_wdata, bus.cpu_dec_dest_reg);
  assign push = bus.cpu_dec_request && !full;
  assign bus.cpu_dec_ready  = !full;
  assign bus.cpu_dec_rvalid = state_q == RESPOND;
  assign bus.cpu_dec_rdata  = rdata_q;
  assign bus.cpu_dec_rtag   = rtag_q;
  assign bus.per_valid = per_valid_q;
  assign bus.per_write = per_write_q;
  assign bus.per_addr  = per_addr_q;
  assign bus.per_wstrb = per_wstrb_q;
  assign bus.per_wdata = per_wdata_q;
  assign error_misaligned = err_q;

  cpu_dec_req_queue #(.DEPTH(REQ_DEPTH)) u_queue (
    .clock(clock), .reset_n(reset_n), .push_i(push), .data_i(push_entry),
    .pop_i(pop), .data_o(head), .full_o(full), .empty_o(empty)
  );

  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    per_valid_d = per_valid_q;
    per_write_d = per_write_q;
    per_addr_d = per_addr_q;
    per_wstrb_d = per_wstrb_q;
    per_wdata_d = per_wdata_q;
    rdata_d = rdata_q;
    rtag_d = rtag_q;
    err_d = err_q | (push & push_entry.bad);
`ifdef CPU_DEC_TIMEOUT_EN
    tmo_cnt_d = state_q == WAIT ? tmo_cnt_q + 16'd1 : '0;
    tmo_err_d = tmo_err_q;
`endif
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        rtag_d = head.tag;
        if (!head.bad) begin
          per_valid_d = 1'b1;
          per_write_d = head.write;
          per_addr_d = head.addr;
          per_wstrb_d = head.wstrb;
          per_wdata_d = head.wdata;
          state_d = ISSUE;
        end else if (!head.write) begin
          // Flagged loads still answer so the CPU read-return FIFO stays in step.
          rdata_d = '0;
          state_d = RESPOND;
        end
      end
      ISSUE: if (bus.per_ready) begin
        per_valid_d = 1'b0;
        state_d = per_write_q ? IDLE : WAIT;
      end
      WAIT: if (bus.per_rvalid) begin
        rdata_d = bus.per_rdata;
        state_d = RESPOND;
      end
`ifdef CPU_DEC_TIMEOUT_EN
      else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        rdata_d = DEADBEEF;
        tmo_err_d = 1'b1;
        state_d = RESPOND;
      end
`endif
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      per_valid_q <= 1'b0;
      per_write_q <= 1'b0;
      per_addr_q <= '0;
      per_wstrb_q <= '0;
      per_wdata_q <= '0;
      rdata_q <= '0;
      rtag_q <= '0;
      err_q <= 1'b0;
`ifdef CPU_DEC_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      per_valid_q <= per_valid_d;
      per_write_q <= per_write_d;
      per_addr_q <= per_addr_d;
      per_wstrb_q <= per_wstrb_d;
      per_wdata_q <= per_wdata_d;
      rdata_q <= rdata_d;
      rtag_q <= rtag_d;
      err_q <= err_d;
`ifdef CPU_DEC_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_dec_read_responder.sv
// tb_cpu_dec_read_responder: scoreboard bench for cpu_dec_read_responder.
// Stimulus pushes expected peripheral requests and load responses into queues;
// a peripheral model and a response monitor pop and compare independently.
module tb_cpu_dec_read_responder;
  import cpu_dec_pkg::*;

  typedef struct { logic write; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } ptx_t;
  typedef struct { logic [31:0] rdata; logic [8:0] rtag; } resp_t;
  typedef struct { logic [31:0] data; int delay; } prd_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic error_misaligned;
`ifdef CPU_DEC_TIMEOUT_EN
  logic timeout_err;
`endif
  int checks = 0;
  int errors = 0;
  int stall_next = 0;
  ptx_t ptx_q[$];
  resp_t resp_q[$];
  prd_t rd_q[$];
  resp_t mon_e;
  logic prev_rvalid = 1'b0;

  always #5 clock = ~clock;

  cpu_dec_read_responder_if bus();

  cpu_dec_read_responder #(.REQ_DEPTH(2)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .error_misaligned(error_misaligned)
`ifdef CPU_DEC_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_per(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    ptx_t t;
    t.write = w; t.addr = a; t.wstrb = s; t.wdata = d;
    ptx_q.push_back(t);
  endtask

  task automatic exp_resp(input logic [31:0] d, input logic [8:0] tag);
    resp_t r;
    r.rdata = d; r.rtag = tag;
    resp_q.push_back(r);
  endtask

  task automatic per_data(input logic [31:0] d, input int delay);
    prd_t p;
    p.data = d; p.delay = delay;
    rd_q.push_back(p);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] d, input logic [4:0] dest);
    int n = 0;
    @(negedge clock);
    bus.cpu_dec_request = 1'b1;
    bus.cpu_dec_write = w;
    bus.cpu_dec_addr = a;
    bus.cpu_dec_size = sz;
    bus.cpu_dec_wdata = d;
    bus.cpu_dec_dest_reg = dest;
    while (!bus.cpu_dec_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got ready=0 for %0d cycles, expected ready", n);
    end
    @(negedge clock);
    bus.cpu_dec_request = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || ptx_q.size() != 0) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("drain_outstanding", 72'(resp_q.size() + ptx_q.size()), 72'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, bus.cpu_dec_ready, 1'b1);
    check({tag, "_rvalid"}, bus.cpu_dec_rvalid, 1'b0);
    check({tag, "_rdata"}, bus.cpu_dec_rdata, 32'h0);
    check({tag, "_rtag"}, bus.cpu_dec_rtag, 9'h0);
    check({tag, "_per_valid"}, bus.per_valid, 1'b0);
    check({tag, "_per_bus"}, {bus.per_write, bus.per_addr, bus.per_wstrb, bus.per_wdata}, 69'h0);
    check({tag, "_error_misaligned"}, error_misaligned, 1'b0);
  endtask

  // Peripheral model: checks each request, optionally stalls per_ready while
  // checking the request stays stable, then returns load data after a delay.
  initial begin : periph
    ptx_t t;
    prd_t r;
    logic [68:0] snap;
    int stall;
    bus.per_ready = 1'b0;
    bus.per_rvalid = 1'b0;
    bus.per_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.per_valid) begin
        snap = {bus.per_write, bus.per_addr, bus.per_wstrb, bus.per_wdata};
        if (ptx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL per_request_unexpected: got per_valid addr=%0h, expected no request", bus.per_addr);
        end else begin
          t = ptx_q.pop_front();
          check("per_write", bus.per_write, t.write);
          check("per_addr", bus.per_addr, t.addr);
          if (t.write) begin
            check("per_wstrb", bus.per_wstrb, t.wstrb);
            check("per_wdata", bus.per_wdata, t.wdata);
          end
        end
        stall = stall_next;
        stall_next = 0;
        for (int i = 0; i < stall; i++) begin
          @(negedge clock);
          check("per_hold_stable", {bus.per_valid, bus.per_write, bus.per_addr, bus.per_wstrb, bus.per_wdata},
                {1'b1, snap});
        end
        bus.per_ready = 1'b1;
        @(negedge clock);
        bus.per_ready = 1'b0;
        if (!snap[68]) begin
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL per_read_data: got load with no read data queued, expected queued data");
          end else begin
            r = rd_q.pop_front();
            if (r.delay >= 0) begin
              repeat (r.delay) @(negedge clock);
              bus.per_rvalid = 1'b1;
              bus.per_rdata = r.data;
              @(negedge clock);
              bus.per_rvalid = 1'b0;
            end
          end
        end
      end
    end
  end

  // Response monitor: every rvalid pulse must match the oldest expected response.
  always @(negedge clock) begin
    if (reset_n && bus.cpu_dec_rvalid) begin
      check("rvalid_single_cycle", prev_rvalid, 1'b0);
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rdata=%0h rtag=%0h, expected no response",
                 bus.cpu_dec_rdata, bus.cpu_dec_rtag);
      end else begin
        mon_e = resp_q.pop_front();
        check("rdata", bus.cpu_dec_rdata, mon_e.rdata);
        check("rtag", bus.cpu_dec_rtag, mon_e.rtag);
      end
    end
    prev_rvalid = bus.cpu_dec_rvalid;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin : stim
    bus.cpu_dec_request = 1'b0;
    bus.cpu_dec_write = 1'b0;
    bus.cpu_dec_addr = '0;
    bus.cpu_dec_size = '0;
    bus.cpu_dec_wdata = '0;
    bus.cpu_dec_dest_reg = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Byte load, lane 3, r7.
    exp_per(1'b0, 32'h0000E000, 4'h0, 32'h0);
    per_data(32'h11223344, 1);
    exp_resp(32'h11223344, 9'b0011_00111);
    send(1'b0, 32'h0000E003, SIZE_BYTE, 32'h0, 5'd7);
    drain();

    // Half store to upper half: no response expected.
    exp_per(1'b1, 32'h0000E000, 4'b1100, 32'hABCDABCD);
    send(1'b1, 32'h0000E002, SIZE_HALF, 32'hFFFFABCD, 5'd0);
    drain();

    // Stalled peripheral with two loads queued behind a byte store.
    stall_next = 10;
    exp_per(1'b1, 32'h0000E000, 4'b0010, 32'h5A5A5A5A);
    exp_per(1'b0, 32'h0000E010, 4'h0, 32'h0);
    exp_per(1'b0, 32'h0000E010, 4'h0, 32'h0);
    per_data(32'hA0A0A0A0, 1);
    per_data(32'hB0B0B0B1, 1);
    exp_resp(32'hA0A0A0A0, 9'b1000_01000);
    exp_resp(32'hB0B0B0B1, 9'b0001_01001);
    send(1'b1, 32'h0000E001, SIZE_BYTE, 32'h1234565A, 5'd0);
    send(1'b0, 32'h0000E010, SIZE_WORD, 32'h0, 5'd8);
    send(1'b0, 32'h0000E011, SIZE_BYTE, 32'h0, 5'd9);
    @(negedge clock);
    bus.cpu_dec_request = 1'b1;
    bus.cpu_dec_write = 1'b0;
    bus.cpu_dec_addr = 32'h0000E020;
    bus.cpu_dec_size = SIZE_WORD;
    bus.cpu_dec_dest_reg = 5'd10;
    check("third_request_ready", bus.cpu_dec_ready, 1'b0);
    @(negedge clock);
    bus.cpu_dec_request = 1'b0;
    drain();

    // Misaligned word load answers with zero and never reaches the bus.
    exp_resp(32'h0, 9'b1000_00011);
    send(1'b0, 32'h0000E001, SIZE_WORD, 32'h0, 5'd3);
    drain();
    check("error_misaligned_set", error_misaligned, 1'b1);
    exp_per(1'b0, 32'h0000E004, 4'h0, 32'h0);
    per_data(32'hCAFEF00D, 2);
    exp_resp(32'hCAFEF00D, 9'b1000_00100);
    send(1'b0, 32'h0000E004, SIZE_WORD, 32'h0, 5'd4);
    drain();

    // Back-to-back loads: slow data first, fast data second, order preserved.
    exp_per(1'b0, 32'h0000E000, 4'h0, 32'h0);
    exp_per(1'b0, 32'h0000E000, 4'h0, 32'h0);
    per_data(32'h01010101, 8);
    per_data(32'h02020202, 1);
    exp_resp(32'h01010101, 9'b0100_00001);
    exp_resp(32'h02020202, 9'b0010_00010);
    send(1'b0, 32'h0000E000, SIZE_HALF, 32'h0, 5'd1);
    send(1'b0, 32'h0000E002, SIZE_BYTE, 32'h0, 5'd2);
    drain();

    // Reset while waiting for load data: abandoned, late data ignored.
    exp_per(1'b0, 32'h0000E008, 4'h0, 32'h0);
    per_data(32'h55555555, 15);
    send(1'b0, 32'h0000E008, SIZE_WORD, 32'h0, 5'd5);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    drain();

`ifdef CPU_DEC_TIMEOUT_EN
    exp_per(1'b0, 32'h0000E00C, 4'h0, 32'h0);
    per_data(32'h0, -1);
    exp_resp(DEADBEEF, 9'b1000_00110);
    send(1'b0, 32'h0000E00C, SIZE_WORD, 32'h0, 5'd6);
    drain();
    check("timeout_err", timeout_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
